sync_fifo_flagged: RTL and testbench

//  Single-clock, parametrised FIFO: same-domain successor to our async FIFO for buffering between blocks on one clock.

---
 rtl/sync_fifo_flagged.sv | 132 +++++++++++++
 tb/tb_sync_fifo_flagged.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a registered or first-word-fall-through read port.
module sync_fifo_flagged #(
    parameter int BITSIZE            = 8,
    parameter int MEMSIZE            = 32,
    parameter int ALMOST_FULL_LEVEL  = 28,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    parameter int FWFT               = 0,
    localparam int ADDRSIZE          = $clog2(MEMSIZE),
    localparam int COUNTSIZE         = ADDRSIZE + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 w_enable,
    input  logic [BITSIZE-1:0]   wdata,
    input  logic                 r_enable,
    input  logic                 err_clear,
    output logic [BITSIZE-1:0]   rdata,
    output logic                 rvalid,
    output logic [COUNTSIZE-1:0] count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [COUNTSIZE-1:0] FULL_COUNT = COUNTSIZE'(MEMSIZE);
    localparam logic [COUNTSIZE-1:0] AF_COUNT   = COUNTSIZE'(ALMOST_FULL_LEVEL);
    localparam logic [COUNTSIZE-1:0] AE_COUNT   = COUNTSIZE'(ALMOST_EMPTY_LEVEL);

    if ((MEMSIZE < 2) || ((MEMSIZE & (MEMSIZE - 1)) != 0)) begin : g_bad_memsize
        $error("sync_fifo_flagged: MEMSIZE must be a power of 2 and >= 2");
    end
    if ((ALMOST_FULL_LEVEL < 1) || (ALMOST_FULL_LEVEL > MEMSIZE)) begin : g_bad_af_level
        $error("sync_fifo_flagged: ALMOST_FULL_LEVEL out of range 1..MEMSIZE");
    end
    if ((ALMOST_EMPTY_LEVEL < 0) || (ALMOST_EMPTY_LEVEL > MEMSIZE - 1)) begin : g_bad_ae_level
        $error("sync_fifo_flagged: ALMOST_EMPTY_LEVEL out of range 0..MEMSIZE-1");
    end

    logic [BITSIZE-1:0]   mem [MEMSIZE];
    logic [ADDRSIZE-1:0]  wptr_q;
    logic [ADDRSIZE-1:0]  rptr_q;
    logic [COUNTSIZE-1:0] count_q;
    logic [COUNTSIZE-1:0] count_next;
    logic                 full_q;
    logic                 empty_q;
    logic                 almost_full_q;
    logic                 almost_empty_q;
    logic                 overflow_q;
    logic                 underflow_q;
    logic                 wr_acc;
    logic                 rd_acc;

    // Acceptance uses the flags registered at the start of the cycle, so a
    // full FIFO can still accept a read and an empty one a write in that cycle.
    assign wr_acc = w_enable & ~full_q & ~reset;
    assign rd_acc = r_enable & ~empty_q & ~reset;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            if (wr_acc) wptr_q <= wptr_q + 1'b1;
            if (rd_acc) rptr_q <= rptr_q + 1'b1;
            count_q        <= count_next;
            full_q         <= (count_next == FULL_COUNT);
            empty_q        <= (count_next == '0);
            almost_full_q  <= (count_next >= AF_COUNT);
            almost_empty_q <= (count_next <= AE_COUNT);
            // A new error in the same cycle as err_clear keeps the flag set.
            overflow_q     <= (overflow_q  & ~err_clear) | (w_enable & full_q);
            underflow_q    <= (underflow_q & ~err_clear) | (r_enable & empty_q);
        end
    end

    // NOTE: the storage array has no reset; the count and pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr_q] <= wdata;
    end

    if (FWFT != 0) begin : g_fwft
        assign rdata  = mem[rptr_q];
        assign rvalid = ~empty_q;
    end else begin : g_registered
        logic [BITSIZE-1:0] rdata_q;
        logic               rvalid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) rdata_q <= mem[rptr_q];
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed bench for sync_fifo_flagged: a registered-read instance and an FWFT instance
// exercised with hand-computed expectations.
module tb_sync_fifo_flagged;

    logic       clk = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;

    // registered-read instance
    logic       w_enable, r_enable, err_clear;
    logic [7:0] wdata, rdata;
    logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [5:0] count;

    // FWFT instance
    logic       f_w_enable, f_r_enable, f_err_clear;
    logic [7:0] f_wdata, f_rdata;
    logic       f_rvalid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [5:0] f_count;

    always #5 clk = ~clk;

    sync_fifo_flagged u_dut (
        .clk(clk), .reset(reset), .w_enable(w_enable), .wdata(wdata),
        .r_enable(r_enable), .err_clear(err_clear), .rdata(rdata), .rvalid(rvalid),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flagged #(.FWFT(1)) u_dut_fwft (
        .clk(clk), .reset(reset), .w_enable(f_w_enable), .wdata(f_wdata),
        .r_enable(f_r_enable), .err_clear(f_err_clear), .rdata(f_rdata), .rvalid(f_rvalid),
        .count(f_count), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({count, full, empty, almost_full, almost_empty, overflow, underflow, rvalid} !==
            {6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: count=%0d full=%b empty=%b af=%b ae=%b ovf=%b unf=%b rvalid=%b, want 0 0 1 0 1 0 0 0",
                     count, full, empty, almost_full, almost_empty, overflow, underflow, rvalid);
        end
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 00", rdata);
        end
        checks++;
        if ({f_count, f_empty, f_rvalid} !== {6'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_fwft: count=%0d empty=%b rvalid=%b, want 0 1 0", f_count, f_empty, f_rvalid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            w_enable = 1'b1;
            wdata    = 8'(i);
            tick();
            checks++;
            if ({count, full, empty, almost_full, almost_empty} !==
                {6'(i + 1), (i + 1 == 32), 1'b0, (i + 1 >= 28), (i + 1 <= 4)}) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d full=%b empty=%b af=%b ae=%b, want count=%0d full=%b empty=0 af=%b ae=%b",
                         i, count, full, empty, almost_full, almost_empty,
                         i + 1, (i + 1 == 32), (i + 1 >= 28), (i + 1 <= 4));
            end
        end
        w_enable = 1'b0;
    endtask

    task automatic test_overflow();
        w_enable = 1'b1;
        wdata    = 8'hAA;
        tick();
        w_enable = 1'b0;
        tick();
        checks++;
        if ({overflow, count, full} !== {1'b1, 6'd32, 1'b1}) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b count=%0d full=%b, want 1 32 1", overflow, count, full);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b want 0", overflow);
        end
        w_enable  = 1'b1;
        err_clear = 1'b1;
        tick();
        w_enable  = 1'b0;
        err_clear = 1'b0;
        checks++;
        if ({overflow, count} !== {1'b1, 6'd32}) begin
            errors++;
            $display("FAIL overflow_set_wins: ovf=%b count=%0d, want 1 32", overflow, count);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 32; i++) begin
            r_enable = 1'b1;
            tick();
            r_enable = 1'b0;
            checks++;
            if ({rvalid, rdata, count} !== {1'b1, 8'(i), 6'(31 - i)}) begin
                errors++;
                $display("FAIL drain_%0d: rvalid=%b rdata=%h count=%0d, want 1 %h %0d",
                         i, rvalid, rdata, count, 8'(i), 31 - i);
            end
            tick();
            checks++;
            if (rvalid !== 1'b0) begin
                errors++;
                $display("FAIL drain_pulse_%0d: rvalid=%b want 0", i, rvalid);
            end
        end
        checks++;
        if ({empty, almost_empty, full} !== 3'b110) begin
            errors++;
            $display("FAIL drain_empty: empty=%b ae=%b full=%b, want 1 1 0", empty, almost_empty, full);
        end
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        checks++;
        if ({underflow, rvalid, count, rdata} !== {1'b1, 1'b0, 6'd0, 8'h1F}) begin
            errors++;
            $display("FAIL underflow_set: unf=%b rvalid=%b count=%0d rdata=%h, want 1 0 0 1f",
                     underflow, rvalid, count, rdata);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        // both requests while empty: write goes in, read is rejected
        w_enable = 1'b1;
        r_enable = 1'b1;
        wdata    = 8'h33;
        tick();
        w_enable = 1'b0;
        r_enable = 1'b0;
        checks++;
        if ({count, underflow, rvalid, empty} !== {6'd1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL empty_rw: count=%0d unf=%b rvalid=%b empty=%b, want 1 1 0 0",
                     count, underflow, rvalid, empty);
        end
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        checks++;
        if ({rvalid, rdata, count} !== {1'b1, 8'h33, 6'd0}) begin
            errors++;
            $display("FAIL empty_rw_read: rvalid=%b rdata=%h count=%0d, want 1 33 0", rvalid, rdata, count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] model_q[$];
        logic [7:0] exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_enable = 1'b1;
            wdata    = 8'h40 + 8'(i);
            model_q.push_back(wdata);
            tick();
        end
        for (int k = 0; k < 100; k++) begin
            w_enable = 1'b1;
            r_enable = 1'b1;
            wdata    = 8'h50 + 8'(k);
            exp      = model_q.pop_front();
            model_q.push_back(wdata);
            tick();
            checks++;
            if ({rvalid, rdata, count} !== {1'b1, exp, 6'd16}) begin
                errors++;
                $display("FAIL b2b_%0d: rvalid=%b rdata=%h count=%0d, want 1 %h 16", k, rvalid, rdata, count, exp);
            end
        end
        w_enable = 1'b0;
        r_enable = 1'b0;
    endtask

    task automatic test_fwft();
        f_w_enable = 1'b1;
        f_wdata    = 8'h5C;
        tick();
        f_w_enable = 1'b0;
        checks++;
        if ({f_empty, f_rvalid, f_rdata, f_count} !== {1'b0, 1'b1, 8'h5C, 6'd1}) begin
            errors++;
            $display("FAIL fwft_head: empty=%b rvalid=%b rdata=%h count=%0d, want 0 1 5c 1",
                     f_empty, f_rvalid, f_rdata, f_count);
        end
        f_w_enable = 1'b1;
        f_wdata    = 8'h6D;
        tick();
        f_w_enable = 1'b0;
        checks++;
        if ({f_rdata, f_count} !== {8'h5C, 6'd2}) begin
            errors++;
            $display("FAIL fwft_hold: rdata=%h count=%0d, want 5c 2", f_rdata, f_count);
        end
        f_r_enable = 1'b1;
        tick();
        checks++;
        if ({f_rdata, f_count, f_rvalid} !== {8'h6D, 6'd1, 1'b1}) begin
            errors++;
            $display("FAIL fwft_pop1: rdata=%h count=%0d rvalid=%b, want 6d 1 1", f_rdata, f_count, f_rvalid);
        end
        tick();
        f_r_enable = 1'b0;
        checks++;
        if ({f_empty, f_rvalid, f_count} !== {1'b1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL fwft_pop2: empty=%b rvalid=%b count=%0d, want 1 0 0", f_empty, f_rvalid, f_count);
        end
    endtask

    task automatic test_reset_midop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r_enable = 1'b1;
        tick();
        r_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            w_enable = 1'b1;
            wdata    = 8'h90 + 8'(i);
            tick();
        end
        checks++;
        if ({count, underflow} !== {6'd10, 1'b1}) begin
            errors++;
            $display("FAIL midop_setup: count=%0d unf=%b, want 10 1", count, underflow);
        end
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        w_enable = 1'b0;
        checks++;
        if ({count, full, empty, almost_full, almost_empty, overflow, underflow, rvalid, rdata} !==
            {6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midop_reset: count=%0d full=%b empty=%b af=%b ae=%b ovf=%b unf=%b rvalid=%b rdata=%h, want 0 0 1 0 1 0 0 0 00",
                     count, full, empty, almost_full, almost_empty, overflow, underflow, rvalid, rdata);
        end
        tick();
        checks++;
        if ({count, empty} !== {6'd0, 1'b1}) begin
            errors++;
            $display("FAIL midop_idle: count=%0d empty=%b, want 0 1", count, empty);
        end
    endtask

    initial begin
        reset       = 1'b1;
        w_enable    = 1'b0;
        r_enable    = 1'b0;
        err_clear   = 1'b0;
        wdata       = 8'h00;
        f_w_enable  = 1'b0;
        f_r_enable  = 1'b0;
        f_err_clear = 1'b0;
        f_wdata     = 8'h00;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_fwft();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
